// File: rtl/fma16_arbiter.sv
// Round-robin front end for one shared combinational fma16 datapath: grants one
// requester per cycle into an issue stage (S1) and captures results in a response stage (S2).
module fma16_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  input  logic [16*NREQ-1:0] req_z,
  input  logic [6*NREQ-1:0] req_op,
  output logic [15:0]       fma_x,
  output logic [15:0]       fma_y,
  output logic [15:0]       fma_z,
  output logic              fma_mul,
  output logic              fma_add,
  output logic              fma_negp,
  output logic              fma_negz,
  output logic [1:0]        fma_roundmode,
  input  logic [15:0]       fma_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_result,
  output logic [31:0]       ops_done
);

  localparam int IW = IDW + 1;
  localparam logic [IDW:0] NREQ_W = IW'(NREQ);

  // Issue stage
  logic           s1_valid_q, s1_valid_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [15:0]    s1_x_q, s1_x_d;
  logic [15:0]    s1_y_q, s1_y_d;
  logic [15:0]    s1_z_q, s1_z_d;
  logic [5:0]     s1_op_q, s1_op_d;

  // Response stage and bookkeeping
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    rsp_result_q, rsp_result_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [31:0]    ops_done_q, ops_done_d;

  logic           s2_load;
  logic           s1_accept;
  logic           found;
  logic           grant;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand;
  logic [IDW:0]   win_nxt;
  logic [15:0]    sel_x, sel_y, sel_z;
  logic [5:0]     sel_op;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // req_ready is asserted only for the round-robin winner and only when S1 can take it;
  // rsp_valid stays high with stable rsp_id/rsp_result until rsp_ready is seen.
  always_comb begin
    s2_load   = s1_valid_q & (~rsp_valid_q | rsp_ready);
    s1_accept = ~s1_valid_q | s2_load;

    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + IW'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = cand[IDW-1:0];
      end
    end

    grant     = found & s1_accept & ~reset;
    req_ready = '0;
    if (grant) req_ready[win_id] = 1'b1;

    sel_x  = '0;
    sel_y  = '0;
    sel_z  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        sel_x  = req_x[16*i +: 16];
        sel_y  = req_y[16*i +: 16];
        sel_z  = req_z[16*i +: 16];
        sel_op = req_op[6*i +: 6];
      end
    end

    win_nxt = {1'b0, win_id} + IW'(1);
    if (win_nxt == NREQ_W) win_nxt = '0;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    s1_z_d       = s1_z_q;
    s1_op_d      = s1_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    ptr_d        = ptr_q;
    ops_done_d   = ops_done_q + 32'(rsp_valid_q & rsp_ready);

    if (grant) begin
      s1_valid_d = 1'b1;
      s1_id_d    = win_id;
      s1_x_d     = sel_x;
      s1_y_d     = sel_y;
      s1_z_d     = sel_z;
      s1_op_d    = sel_op;
      ptr_d      = win_nxt[IDW-1:0];
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // S2 may drain and refill in the same cycle, so load takes priority over clear.
    if (s2_load) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = s1_id_q;
      rsp_result_d = fma_result;
    end else if (rsp_valid_q & rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_z_q       <= '0;
      s1_op_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      ptr_q        <= '0;
      ops_done_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s1_z_q       <= s1_z_d;
      s1_op_q      <= s1_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      ptr_q        <= ptr_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // An empty issue stage presents all-zero inputs to the datapath.
  assign fma_x         = s1_valid_q ? s1_x_q : 16'h0000;
  assign fma_y         = s1_valid_q ? s1_y_q : 16'h0000;
  assign fma_z         = s1_valid_q ? s1_z_q : 16'h0000;
  assign fma_roundmode = s1_valid_q ? s1_op_q[5:4] : 2'b00;
  assign fma_mul       = s1_valid_q & s1_op_q[3];
  assign fma_add       = s1_valid_q & s1_op_q[2];
  assign fma_negp      = s1_valid_q & s1_op_q[1];
  assign fma_negz      = s1_valid_q & s1_op_q[0];

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_fma16_arbiter.sv
// Directed bench for fma16_arbiter with a table-driven fma16 stand-in, a grant/response
// scoreboard and protocol monitors.
module tb_fma16_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_x, req_y, req_z;
  logic [6*NREQ-1:0] req_op;
  logic [15:0]       fma_x, fma_y, fma_z;
  logic              fma_mul, fma_add, fma_negp, fma_negz;
  logic [1:0]        fma_roundmode;
  logic [15:0]       fma_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_result;
  logic [31:0]       ops_done;

  logic [15:0] bx [NREQ];
  logic [15:0] by [NREQ];
  logic [15:0] bz [NREQ];
  logic [5:0]  bop[NREQ];

  logic [NREQ-1:0] sticky;
  logic [NREQ-1:0] last_acc;
  logic [W-1:0]    exp_q[$];
  int              grant_q[$];
  int              n_checks = 0;
  int              n_errors = 0;

  fma16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_op(req_op),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode), .fma_result(fma_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // fma16 stand-in: hand-computed FP16 results for the numeric vectors, a fixed
  // operand mix otherwise so routing errors still show up in the result.
  function automatic logic [15:0] fma_ref(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z, input logic [5:0] op);
    case ({x, y, z, op})
      {16'h3C00, 16'h4000, 16'h0000, 6'b001000}: return 16'h4000;
      {16'h3C00, 16'h3C00, 16'h3C00, 6'b001100}: return 16'h4000;
      {16'h3C00, 16'h3C00, 16'h3C00, 6'b001101}: return 16'h0000;
      default: return x ^ {y[7:0], y[15:8]} ^ {z[14:0], z[15]} ^ {10'd0, op};
    endcase
  endfunction

  assign fma_result = fma_ref(fma_x, fma_y, fma_z,
                              {fma_roundmode, fma_mul, fma_add, fma_negp, fma_negz});

  always_comb begin
    req_x  = '0;
    req_y  = '0;
    req_z  = '0;
    req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[16*i +: 16] = bx[i];
      req_y[16*i +: 16] = by[i];
      req_z[16*i +: 16] = bz[i];
      req_op[6*i +: 6]  = bop[i];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled on the falling edge.
  task automatic monitor();
    logic            prev_reset = 1'b1;
    logic            prev_rv = 1'b0;
    logic            prev_rr = 1'b0;
    logic [IDW-1:0]  prev_id = '0;
    logic [15:0]     prev_res = '0;
    logic [NREQ-1:0] prev_valid = '0;
    logic [NREQ-1:0] prev_ready = '0;
    logic [W-1:0]    e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        last_acc = '0;
      end else begin
        check_val("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check_val("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("sb_rsp_id", 32'(rsp_id), 32'(e[W-1:16]));
            check_val("sb_rsp_result", 32'(rsp_result), 32'(e[15:0]));
          end
        end
        if (!prev_reset && prev_rv && !prev_rr) begin
          check_val("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check_val("rsp_hold_id", 32'(rsp_id), 32'(prev_id));
          check_val("rsp_hold_result", 32'(rsp_result), 32'(prev_res));
        end
        for (int i = 0; i < NREQ; i++)
          if (!prev_reset && prev_valid[i] && !prev_ready[i])
            check_val("req_hold_valid", 32'(req_valid[i]), 32'd1);
        last_acc = req_valid & req_ready;
        for (int i = 0; i < NREQ; i++) begin
          if (last_acc[i]) begin
            exp_q.push_back({IDW'(i), fma_ref(bx[i], by[i], bz[i], bop[i])});
            grant_q.push_back(i);
          end
        end
      end
      prev_reset = reset;
      prev_rv    = rsp_valid;
      prev_rr    = rsp_ready;
      prev_id    = rsp_id;
      prev_res   = rsp_result;
      prev_valid = req_valid;
      prev_ready = req_ready;
    end
  endtask

  // Advance one edge; accepted requests drop, sticky requests re-arm.
  task automatic step();
    @(posedge clk);
    #1;
    req_valid = (req_valid & ~last_acc) | sticky;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (req_valid == '0 && exp_q.size() == 0 && !rsp_valid) break;
      step();
    end
    check_val("drain_req_valid", 32'(req_valid), 32'd0);
    check_val("drain_exp_q", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g0;
    logic [15:0] hold_res;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    sticky    = '0;
    last_acc  = '0;
    for (int i = 0; i < NREQ; i++) begin
      bx[i] = '0; by[i] = '0; bz[i] = '0; bop[i] = '0;
    end
    fork
      monitor();
    join_none

    // Reset state
    step();
    req_valid = 4'b1111;
    settle();
    check_val("rst_req_ready", 32'(req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_val("rst_rsp_result", 32'(rsp_result), 32'd0);
    check_val("rst_ops_done", ops_done, 32'd0);
    check_val("rst_fma_xyz", 32'(fma_x | fma_y | fma_z), 32'd0);
    check_val("rst_fma_ctl", 32'({fma_roundmode, fma_mul, fma_add, fma_negp, fma_negz}), 32'd0);
    req_valid = '0;
    reset     = 1'b0;
    step();

    // Single request from requester 1
    bx[1] = 16'h3C00; by[1] = 16'h4000; bz[1] = 16'h0000; bop[1] = 6'b001000;
    req_valid = 4'b0010;
    settle();
    check_val("t1_req_ready", 32'(req_ready), 32'b0010);
    step();
    check_val("t1_fma_x", 32'(fma_x), 32'h3C00);
    check_val("t1_fma_mul", 32'(fma_mul), 32'd1);
    check_val("t1_rsp_early", 32'(rsp_valid), 32'd0);
    step();
    check_val("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("t1_rsp_id", 32'(rsp_id), 32'd1);
    check_val("t1_rsp_result", 32'(rsp_result), 32'h4000);
    step();
    check_val("t1_ops_done", ops_done, 32'd1);
    check_val("t1_rsp_clear", 32'(rsp_valid), 32'd0);

    // All four valid after reset: grants 0..3, responses back-to-back
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      bx[i]  = 16'h3800 + 16'(i) * 16'h0111;
      by[i]  = 16'h4400 - 16'(i);
      bz[i]  = 16'h0100 << i;
      bop[i] = {2'(i), 4'b1010};
    end
    req_valid = 4'b1111;
    settle();
    for (int k = 0; k < NREQ; k++) begin
      check_val("t2_req_ready", 32'(req_ready), 32'(1 << k));
      step();
      if (k > 0) begin
        check_val("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check_val("t2_rsp_id", 32'(rsp_id), 32'(k - 1));
      end
    end
    check_val("t2_ready_idle", 32'(req_ready), 32'd0);
    step();
    check_val("t2_rsp_valid_last", 32'(rsp_valid), 32'd1);
    check_val("t2_rsp_id_last", 32'(rsp_id), 32'd3);
    step();
    check_val("t2_ops_done", ops_done, 32'd4);
    drain();

    // Fairness: 0 and 2 held, grants alternate
    sticky    = 4'b0101;
    req_valid = 4'b0101;
    settle();
    for (int k = 0; k < 8; k++) begin
      check_val("t3_alternate", 32'(req_ready), (k % 2 == 0) ? 32'b0001 : 32'b0100);
      step();
    end
    sticky = '0;
    drain();

    // Backpressure: two buffered, then nothing granted until the consumer is ready
    do_reset();
    g0 = grant_q.size();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    settle();
    check_val("t4_ready0", 32'(req_ready), 32'b0001);
    step();
    check_val("t4_ready1", 32'(req_ready), 32'b0010);
    step();
    hold_res = fma_ref(bx[0], by[0], bz[0], bop[0]);
    for (int k = 0; k < 3; k++) begin
      check_val("t4_ready_blocked", 32'(req_ready), 32'd0);
      check_val("t4_hold_id", 32'(rsp_id), 32'd0);
      check_val("t4_hold_result", 32'(rsp_result), 32'(hold_res));
      step();
    end
    check_val("t4_grant_count", 32'(grant_q.size() - g0), 32'd2);
    rsp_ready = 1'b1;
    settle();
    check_val("t4_same_cycle_grant", 32'(req_ready), 32'b0100);
    drain();
    for (int k = 0; k < NREQ; k++)
      check_val("t4_grant_order", 32'(grant_q[g0 + k]), 32'(k));
    check_val("t4_ops_done", ops_done, 32'd4);

    // Add path: 1*1+1 = 2, 1*1-1 = +0 under round-to-nearest-even
    bx[0] = 16'h3C00; by[0] = 16'h3C00; bz[0] = 16'h3C00; bop[0] = 6'b001100;
    req_valid = 4'b0001;
    settle();
    step();
    check_val("t5_fma_add", 32'(fma_add), 32'd1);
    check_val("t5_fma_z", 32'(fma_z), 32'h3C00);
    step();
    check_val("t5_add_valid", 32'(rsp_valid), 32'd1);
    check_val("t5_add_result", 32'(rsp_result), 32'h4000);
    bop[0] = 6'b001101;
    req_valid = 4'b0001;
    settle();
    step();
    check_val("t5_fma_negz", 32'(fma_negz), 32'd1);
    step();
    check_val("t5_sub_result", 32'(rsp_result), 32'h0000);
    drain();

    // Reset while S1 and S2 both hold operations
    for (int i = 0; i < NREQ; i++) bop[i] = {2'(i), 4'b1001};
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    settle();
    step();
    step();
    check_val("t6_pre_rsp_valid", 32'(rsp_valid), 32'd1);
    reset     = 1'b1;
    req_valid = 4'b1111;
    step();
    reset = 1'b0;
    settle();
    check_val("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("t6_ops_done", ops_done, 32'd0);
    check_val("t6_fma_x", 32'(fma_x), 32'd0);
    check_val("t6_first_grant", 32'(req_ready), 32'b0001);
    g0 = grant_q.size();
    rsp_ready = 1'b1;
    drain();
    for (int k = 0; k < NREQ; k++)
      check_val("t6_grant_order", 32'(grant_q[g0 + k]), 32'(k));
    check_val("t6_ops_done_after", ops_done, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
